// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, standard bit timing and data width.
package uart_pkg;

   localparam int unsigned UART_CLKS_PER_BIT_115200 = 217;
   localparam int unsigned UART_DATA_BITS           = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_rx_framed_if.sv
// Serial line and received-byte signals between the receiver (slave) and its line/consumer side (master).
interface uart_rx_framed_if;
   import uart_pkg::*;

   logic                      RX;
   logic                      o_RX_DV;
   logic [UART_DATA_BITS-1:0] o_RX_Byte;
   logic                      o_Frame_Err;
   logic                      o_RX_Busy;

   modport master (
      output RX,
      input  o_RX_DV, o_RX_Byte, o_Frame_Err, o_RX_Busy
   );

   modport slave (
      input  RX,
      output o_RX_DV, o_RX_Byte, o_Frame_Err, o_RX_Busy
   );

endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input pin, with a configurable reset value.
module uart_sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_framed.sv
// 8N1 UART receiver: synchronised input, start-glitch rejection, stop-bit framing check,
// WAIT_HIGH lockout after a framing error so a held-low line cannot re-trigger a start.
module uart_rx_framed
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_115200
) (
   input  logic            CLK,
   input  logic            RST,
   uart_rx_framed_if.slave bus
);

   localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W    = $clog2(UART_DATA_BITS);
   localparam int unsigned LAST_IDX = UART_DATA_BITS - 1;

   logic                      rx_s;
   rx_state_e                 state_q;
   logic [CNT_W-1:0]          clk_cnt_q;
   logic [IDX_W-1:0]          bit_idx_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [UART_DATA_BITS-1:0] byte_q;
   logic                      dv_q;
   logic                      err_q;
   logic                      busy_q;

   uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   (bus.RX),
      .q_o   (rx_s)
   );

   // Frame FSM; busy_q tracks (next state != IDLE) so it is registered alongside the state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         byte_q    <= '0;
         dv_q      <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         dv_q  <= 1'b0;
         err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_q   <= START;
                  clk_cnt_q <= '0;
                  bit_idx_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            START: begin
               if (clk_cnt_q == CNT_W'(HALF_BIT)) begin
                  clk_cnt_q <= '0;
                  bit_idx_q <= '0;
                  if (!rx_s) begin
                     state_q <= DATA;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
            DATA: begin
               if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                  clk_cnt_q          <= '0;
                  shift_q[bit_idx_q] <= rx_s;
                  if (bit_idx_q == IDX_W'(LAST_IDX)) begin
                     state_q   <= STOP;
                     bit_idx_q <= '0;
                  end else begin
                     bit_idx_q <= bit_idx_q + IDX_W'(1);
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
            STOP: begin
               if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                  clk_cnt_q <= '0;
                  bit_idx_q <= '0;
                  if (rx_s) begin
                     byte_q  <= shift_q;
                     dv_q    <= 1'b1;
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= WAIT_HIGH;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
            WAIT_HIGH: begin
               if (rx_s) begin
                  state_q   <= IDLE;
                  clk_cnt_q <= '0;
                  bit_idx_q <= '0;
                  busy_q    <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               clk_cnt_q <= '0;
               bit_idx_q <= '0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_RX_DV     = dv_q;
   assign bus.o_RX_Byte   = byte_q;
   assign bus.o_Frame_Err = err_q;
   assign bus.o_RX_Busy   = busy_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: fast instance (8 clocks/bit) plus a 217 clocks/bit loopback instance.
module tb_uart_rx_framed;

   localparam int unsigned C1 = 8;
   localparam int unsigned C2 = 217;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   uart_rx_framed_if u_if1 ();
   uart_rx_framed_if u_if2 ();

   uart_rx_framed #(.CLKS_PER_BIT(C1)) dut1 (.CLK(clk), .RST(rst), .bus(u_if1));
   uart_rx_framed #(.CLKS_PER_BIT(C2)) dut2 (.CLK(clk), .RST(rst), .bus(u_if2));

   // Output monitors, sampled mid-cycle.
   int         dv1_total = 0, err1_total = 0, dv1_cyc = 0, both_high = 0, stray_byte = 0;
   logic [7:0] dv1_byte = 8'h00, prev_byte = 8'h00;
   logic       prev_rst = 1'b1;
   int         dv2_total = 0, err2_total = 0;
   logic [7:0] dv2_byte = 8'h00;

   always @(negedge clk) begin
      if (u_if1.o_RX_DV) begin
         dv1_total++;
         dv1_cyc  = cyc;
         dv1_byte = u_if1.o_RX_Byte;
      end
      if (u_if1.o_Frame_Err) err1_total++;
      if (u_if1.o_RX_DV && u_if1.o_Frame_Err) both_high++;
      if (u_if1.o_RX_Byte !== prev_byte && !u_if1.o_RX_DV && !prev_rst) stray_byte++;
      prev_byte = u_if1.o_RX_Byte;
      prev_rst  = rst;
      if (u_if2.o_RX_DV) begin
         dv2_total++;
         dv2_byte = u_if2.o_RX_Byte;
      end
      if (u_if2.o_Frame_Err) err2_total++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_rx(input int which, input logic v);
      if (which == 1) u_if1.RX = v;
      else            u_if2.RX = v;
   endtask

   task automatic drive(input int which, input logic v, input int n);
      set_rx(which, v);
      repeat (n) tick();
   endtask

   task automatic send(input int which, input logic [7:0] d, input logic stop, input int cpb);
      drive(which, 1'b0, cpb);
      for (int i = 0; i < 8; i++) drive(which, d[i], cpb);
      drive(which, stop, cpb);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_dv;
      int         exp_err;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int s, d0, e0, d1c, busy_lost, waited;
      logic [7:0] b1;
      logic [7:0] lb [3];

      vecs[0] = '{data: 8'h55, stop: 1'b1, exp_dv: 1, exp_err: 0, exp_byte: 8'h55};
      vecs[1] = '{data: 8'h00, stop: 1'b1, exp_dv: 1, exp_err: 0, exp_byte: 8'h00};
      vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_dv: 1, exp_err: 0, exp_byte: 8'hFF};
      vecs[3] = '{data: 8'h7E, stop: 1'b0, exp_dv: 0, exp_err: 1, exp_byte: 8'hFF};
      vecs[4] = '{data: 8'h81, stop: 1'b1, exp_dv: 1, exp_err: 0, exp_byte: 8'h81};
      lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A;

      u_if1.RX = 1'b1;
      u_if2.RX = 1'b1;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check("reset_dv",   int'(u_if1.o_RX_DV),     0);
      check("reset_byte", int'(u_if1.o_RX_Byte),   0);
      check("reset_err",  int'(u_if1.o_Frame_Err), 0);
      check("reset_busy", int'(u_if1.o_RX_Busy),   0);
      drive(1, 1'b1, 4);

      // Single frame from idle: DV lands 79 cycles after the start bit is driven.
      s = cyc; d0 = dv1_total; e0 = err1_total;
      send(1, 8'h55, 1'b1, C1);
      drive(1, 1'b1, 2 * C1);
      check("f55_dv_count",   dv1_total - d0, 1);
      check("f55_dv_latency", dv1_cyc - s, 79);
      check("f55_byte",       int'(dv1_byte), 8'h55);
      check("f55_no_err",     err1_total - e0, 0);

      foreach (vecs[i]) begin
         d0 = dv1_total; e0 = err1_total;
         send(1, vecs[i].data, vecs[i].stop, C1);
         drive(1, 1'b1, 2 * C1);
         check($sformatf("vec%0d_dv", i),   dv1_total - d0, vecs[i].exp_dv);
         check($sformatf("vec%0d_err", i),  err1_total - e0, vecs[i].exp_err);
         check($sformatf("vec%0d_byte", i), int'(u_if1.o_RX_Byte), int'(vecs[i].exp_byte));
      end

      // Back-to-back frames with no idle gap.
      d0 = dv1_total; e0 = err1_total;
      send(1, 8'hA5, 1'b1, C1);
      d1c = dv1_cyc; b1 = dv1_byte;
      send(1, 8'h3C, 1'b1, C1);
      drive(1, 1'b1, 2 * C1);
      check("b2b_dv_count", dv1_total - d0, 2);
      check("b2b_spacing",  dv1_cyc - d1c, 80);
      check("b2b_byte1",    int'(b1), 8'hA5);
      check("b2b_byte2",    int'(dv1_byte), 8'h3C);
      check("b2b_no_err",   err1_total - e0, 0);

      // Start glitch: two cycles low.
      d0 = dv1_total; e0 = err1_total;
      drive(1, 1'b0, 2);
      drive(1, 1'b1, 2);
      check("glitch_busy_rise", int'(u_if1.o_RX_Busy), 1);
      drive(1, 1'b1, 20);
      check("glitch_busy_fall", int'(u_if1.o_RX_Busy), 0);
      check("glitch_no_dv",     dv1_total - d0, 0);
      check("glitch_no_err",    err1_total - e0, 0);

      // Framing error with line held low afterwards.
      send(1, 8'h11, 1'b1, C1);
      drive(1, 1'b1, 2 * C1);
      check("ferr_prior_byte", int'(u_if1.o_RX_Byte), 8'h11);
      d0 = dv1_total; e0 = err1_total;
      send(1, 8'h7E, 1'b0, C1);
      busy_lost = 0;
      for (int i = 0; i < 40; i++) begin
         drive(1, 1'b0, 1);
         if (!u_if1.o_RX_Busy) busy_lost++;
      end
      check("ferr_pulse",     err1_total - e0, 1);
      check("ferr_busy_low",  busy_lost, 0);
      check("ferr_byte_held", int'(u_if1.o_RX_Byte), 8'h11);
      u_if1.RX = 1'b1;
      waited = 0;
      while (u_if1.o_RX_Busy && waited < 10) begin
         tick();
         waited++;
      end
      check("ferr_busy_release", int'(u_if1.o_RX_Busy), 0);
      drive(1, 1'b1, 2 * C1);
      check("ferr_no_dv",    dv1_total - d0, 0);
      check("ferr_one_err",  err1_total - e0, 1);

      // Reset during data bit 4 of 0xC3, then a clean 0x96.
      d0 = dv1_total; e0 = err1_total;
      drive(1, 1'b0, C1);
      for (int i = 0; i < 4; i++) drive(1, ((8'hC3 >> i) & 8'h01) != 0, C1);
      drive(1, 1'b0, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_dv",   int'(u_if1.o_RX_DV),     0);
      check("rst_byte", int'(u_if1.o_RX_Byte),   0);
      check("rst_err",  int'(u_if1.o_Frame_Err), 0);
      check("rst_busy", int'(u_if1.o_RX_Busy),   0);
      drive(1, 1'b1, 2 * C1);
      send(1, 8'h96, 1'b1, C1);
      drive(1, 1'b1, 2 * C1);
      check("rst_one_dv", dv1_total - d0, 1);
      check("rst_no_err", err1_total - e0, 0);
      check("rst_byte96", int'(dv1_byte), 8'h96);

      // Loopback at the real bit rate.
      d0 = dv2_total;
      foreach (lb[i]) begin
         send(2, lb[i], 1'b1, C2);
         drive(2, 1'b1, 2);
         check($sformatf("loop%0d_dv", i),   dv2_total - d0, i + 1);
         check($sformatf("loop%0d_byte", i), int'(dv2_byte), int'(lb[i]));
      end
      check("loop_no_err", err2_total, 0);

      check("dv_err_exclusive", both_high, 0);
      check("byte_only_with_dv", stray_byte, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
